// File: rtl/sid_bus_if_mc.sv
// CPU-side bus front end: synchronises and debounces the pads, qualifies phi2,
// queues write cycles in a small FIFO and serves read data back to the CPU.
module sid_bus_if_mc #(
  parameter int AW       = 5,
  parameter int NCS      = 2,
  parameter int DB_LEN   = 4,
  parameter int RISE_LEN = 7,
  parameter int FDEPTH   = 4,
  localparam int CSW     = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  pad_a_i,
  input  logic [7:0]     pad_d_i,
  output logic [7:0]     pad_d_o,
  output logic           pad_d_oe,
  input  logic           pad_r_wn_i,
  input  logic [NCS-1:0] pad_csn_i,
  input  logic           pad_phi2_i,
  output logic           clk_en,
  output logic           wr_valid,
  input  logic           wr_ready,
  output logic [CSW-1:0] wr_cs,
  output logic [AW-1:0]  wr_addr,
  output logic [7:0]     wr_data,
  output logic [CSW-1:0] bus_rcs,
  output logic [AW-1:0]  bus_raddr,
  input  logic [7:0]     bus_rdata,
  output logic           rd_strobe,
  output logic           ovf,
  input  logic           ovf_clr
);

  localparam int NB = AW + 9 + NCS;
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = CSW + AW + 8;
  localparam logic [NB-1:0] DB_RST = {{NCS{1'b1}}, {(AW + 9){1'b0}}};
  localparam logic [3:0] DB_LAST   = 4'(DB_LEN - 1);
  localparam logic [3:0] RISE_LAST = 4'(RISE_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

  typedef enum logic {PH_LOW, PH_HIGH} ph_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q;
  logic          p1_q, p2_q;

  logic [NB-1:0] db_q, db_d;
  logic [3:0]    dbc_q [NB];
  logic [3:0]    dbc_d [NB];

  logic [AW-1:0]  a_db;
  logic [7:0]     d_db;
  logic           rwn_db;
  logic [NCS-1:0] csn_db;
  logic           sel;
  logic [CSW-1:0] sel_idx;

  ph_t        ph_q, ph_d;
  logic [3:0] rc_q, rc_d;
  logic       clk_en_q, clk_en_d;

  logic [EW-1:0] mem_q [FDEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_req, push, pop, full;

  logic [7:0] dout_q;
  logic       oe_q, oe_d;

  assign raw = {pad_csn_i, pad_r_wn_i, pad_d_i, pad_a_i};

  // Chip selects synchronise to their inactive level so reset never fakes a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= DB_RST;
      s2_q <= DB_RST;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      p1_q <= pad_phi2_i;
      p2_q <= p1_q;
    end
  end

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NB; i++) begin
      dbc_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else                     dbc_d[i] = dbc_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= DB_RST;
      for (int i = 0; i < NB; i++) dbc_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NB; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  assign a_db   = db_q[AW-1:0];
  assign d_db   = db_q[AW+7:AW];
  assign rwn_db = db_q[AW+8];
  assign csn_db = db_q[NB-1:AW+9];

  // Scanning downward leaves the lowest active index as the winner
  always_comb begin
    sel     = 1'b0;
    sel_idx = '0;
    for (int i = NCS - 1; i >= 0; i--) begin
      if (!csn_db[i]) begin
        sel     = 1'b1;
        sel_idx = CSW'(i);
      end
    end
  end

  always_comb begin
    ph_d     = ph_q;
    rc_d     = '0;
    clk_en_d = 1'b0;
    case (ph_q)
      PH_LOW: begin
        if (p2_q) begin
          if (rc_q == RISE_LAST) ph_d = PH_HIGH;
          else                   rc_d = rc_q + 4'd1;
        end
      end
      PH_HIGH: begin
        if (!p2_q) begin
          ph_d     = PH_LOW;
          clk_en_d = 1'b1;
        end
      end
      default: ph_d = PH_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= PH_LOW;
      rc_q     <= '0;
      clk_en_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      rc_q     <= rc_d;
      clk_en_q <= clk_en_d;
    end
  end

  // A push into a full FIFO survives only when the head leaves in the same cycle
  always_comb begin
    push_req = clk_en_q & ~rwn_db & sel;
    full     = (cnt_q == FULL_CNT);
    pop      = (cnt_q != '0) & wr_ready;
    push     = push_req & (~full | pop);
    wp_d     = push ? wp_q + PW'(1) : wp_q;
    rp_d     = pop ? rp_q + PW'(1) : rp_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (ovf_clr)          ovf_d = 1'b0;
    if (push_req && !push) ovf_d = 1'b1;
    oe_d     = rwn_db & sel & (ph_q == PH_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      dout_q <= bus_rdata;
      oe_q   <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {sel_idx, a_db, d_db};
  end

  assign {wr_cs, wr_addr, wr_data} = mem_q[rp_q];
  assign wr_valid  = (cnt_q != '0);
  assign clk_en    = clk_en_q;
  assign rd_strobe = clk_en_q & rwn_db & sel;
  assign bus_rcs   = sel_idx;
  assign bus_raddr = a_db;
  assign ovf       = ovf_q;
  assign pad_d_o   = dout_q;
  assign pad_d_oe  = oe_q;

endmodule

// File: tb/tb_sid_bus_if_mc.sv
// Self-checking bench for sid_bus_if_mc: vector table of bus cycles plus
// hand sequences for FIFO overflow, concurrent pop/push, glitches and reset.
module tb_sid_bus_if_mc;

  localparam int AW = 5, NCS = 2, DB_LEN = 4, RISE_LEN = 7, FDEPTH = 4, CSW = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-1:0]  pad_a_i;
  logic [7:0]     pad_d_i;
  logic [7:0]     pad_d_o;
  logic           pad_d_oe;
  logic           pad_r_wn_i;
  logic [NCS-1:0] pad_csn_i;
  logic           pad_phi2_i;
  logic           clk_en;
  logic           wr_valid;
  logic           wr_ready;
  logic [CSW-1:0] wr_cs;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic [CSW-1:0] bus_rcs;
  logic [AW-1:0]  bus_raddr;
  logic [7:0]     bus_rdata;
  logic           rd_strobe;
  logic           ovf;
  logic           ovf_clr;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rd_cnt = 0;
  logic [13:0] exp_q [$];

  typedef struct {
    logic [1:0] csn;
    logic       rwn;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] rdata;
    int         hl;
    int         exp_en;
    int         exp_rd;
    logic       exp_push;
    logic       exp_cs;
    logic       exp_sel;
  } vec_t;

  vec_t vecs [7];

  sid_bus_if_mc #(
    .AW(AW), .NCS(NCS), .DB_LEN(DB_LEN), .RISE_LEN(RISE_LEN), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pad_a_i(pad_a_i), .pad_d_i(pad_d_i),
    .pad_d_o(pad_d_o), .pad_d_oe(pad_d_oe), .pad_r_wn_i(pad_r_wn_i),
    .pad_csn_i(pad_csn_i), .pad_phi2_i(pad_phi2_i), .clk_en(clk_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_cs(wr_cs),
    .wr_addr(wr_addr), .wr_data(wr_data), .bus_rcs(bus_rcs),
    .bus_raddr(bus_raddr), .bus_rdata(bus_rdata), .rd_strobe(rd_strobe),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] csn, input logic rwn,
                               input logic [4:0] a, input logic [7:0] d);
    pad_csn_i  = csn;
    pad_r_wn_i = rwn;
    pad_a_i    = a;
    pad_d_i    = d;
    repeat (8) tick();
  endtask

  // Raise phi2 for hl cycles, drop it, optionally pulse wr_ready/ovf_clr in the clk_en cycle
  task automatic phi2Pulse(input int hl, input logic rdy, input logic clr);
    logic rdy_save, clr_save;
    bit   seen;
    seen = 0;
    pad_phi2_i = 1'b1;
    repeat (hl) tick();
    pad_phi2_i = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (clk_en) begin
        seen     = 1;
        rdy_save = wr_ready;
        clr_save = ovf_clr;
        if (rdy) wr_ready = 1'b1;
        if (clr) ovf_clr = 1'b1;
        tick();
        wr_ready = rdy_save;
        ovf_clr  = clr_save;
      end
    end
    repeat (3) tick();
  endtask

  // Scoreboard: a head is compared at the negedge before the edge that pops it
  always @(negedge clk) begin
    if (rst_n) begin
      if (clk_en) en_cnt++;
      if (rd_strobe) rd_cnt++;
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: actual=%0h required=none", {wr_cs, wr_addr, wr_data});
        end else begin
          checkOutput("fifo_head", {18'd0, wr_cs, wr_addr, wr_data}, {18'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, r0;

    vecs[0] = '{2'b00, 1'b0, 5'h03, 8'h5A, 8'h00, 10, 1, 0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'b11, 1'b0, 5'h07, 8'h11, 8'h00, 10, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 5'h0C, 8'h11, 8'hC3, 10, 1, 1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 1'b1, 5'h15, 8'h22, 8'h96, 10, 1, 1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{2'b00, 1'b0, 5'h09, 8'h66, 8'h00,  6, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'b00, 1'b0, 5'h0B, 8'h77, 8'h00,  7, 1, 0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 1'b0, 5'h1F, 8'hFF, 8'h00, 10, 1, 0, 1'b1, 1'b1, 1'b1};

    rst_n      = 1'b0;
    pad_a_i    = '0;
    pad_d_i    = '0;
    pad_r_wn_i = 1'b0;
    pad_csn_i  = 2'b11;
    pad_phi2_i = 1'b0;
    wr_ready   = 1'b0;
    bus_rdata  = 8'h77;
    ovf_clr    = 1'b0;

    repeat (3) tick();
    checkOutput("rst_clk_en", clk_en, 0);
    checkOutput("rst_wr_valid", wr_valid, 0);
    checkOutput("rst_rd_strobe", rd_strobe, 0);
    checkOutput("rst_pad_d_oe", pad_d_oe, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_pad_d_o", pad_d_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic write cycle and clk_en timing");
    applyStimulus(2'b01, 1'b0, 5'h18, 8'hA5);
    exp_q.push_back({1'b1, 5'h18, 8'hA5});
    pad_phi2_i = 1'b1;
    repeat (10) tick();
    pad_phi2_i = 1'b0;
    tick();
    checkOutput("clk_en_edge1", clk_en, 0);
    tick();
    checkOutput("clk_en_edge2", clk_en, 0);
    tick();
    checkOutput("clk_en_edge3", clk_en, 1);
    checkOutput("wr_valid_edge3", wr_valid, 0);
    tick();
    checkOutput("clk_en_edge4", clk_en, 0);
    checkOutput("wr_valid_edge4", wr_valid, 1);
    checkOutput("head_cs", wr_cs, 1);
    checkOutput("head_addr", wr_addr, 5'h18);
    checkOutput("head_data", wr_data, 8'hA5);
    wr_ready = 1'b1;
    repeat (3) tick();
    checkOutput("drained_1", wr_valid, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      bus_rdata = vecs[i].rdata;
      applyStimulus(vecs[i].csn, vecs[i].rwn, vecs[i].a, vecs[i].d);
      if (vecs[i].exp_sel) checkOutput("vec_bus_rcs", bus_rcs, vecs[i].exp_cs);
      checkOutput("vec_bus_raddr", bus_raddr, vecs[i].a);
      e0 = en_cnt;
      r0 = rd_cnt;
      if (vecs[i].exp_push) exp_q.push_back({vecs[i].exp_cs, vecs[i].a, vecs[i].d});
      phi2Pulse(vecs[i].hl, 1'b0, 1'b0);
      repeat (4) tick();
      checkOutput("vec_clk_en_count", en_cnt - e0, vecs[i].exp_en);
      checkOutput("vec_rd_strobe_count", rd_cnt - r0, vecs[i].exp_rd);
    end
    checkOutput("vec_sb_empty", exp_q.size(), 0);

    $display("[TB] read cycle");
    bus_rdata = 8'h3C;
    applyStimulus(2'b10, 1'b1, 5'h05, 8'h00);
    checkOutput("rd_oe_before", pad_d_oe, 0);
    r0 = rd_cnt;
    pad_phi2_i = 1'b1;
    repeat (12) tick();
    checkOutput("rd_oe_high", pad_d_oe, 1);
    checkOutput("rd_pad_d_o", pad_d_o, 8'h3C);
    pad_phi2_i = 1'b0;
    repeat (6) tick();
    checkOutput("rd_strobe_once", rd_cnt - r0, 1);
    checkOutput("rd_oe_after", pad_d_oe, 0);

    $display("[TB] overflow");
    wr_ready = 1'b0;
    for (int k = 0; k <= FDEPTH; k++) begin
      applyStimulus(2'b01, 1'b0, 5'(k + 2), 8'(8'h10 + k));
      if (k < FDEPTH) exp_q.push_back({1'b1, 5'(k + 2), 8'(8'h10 + k)});
      if (k == FDEPTH) checkOutput("ovf_before_drop", ovf, 0);
      phi2Pulse(10, 1'b0, 1'b0);
    end
    checkOutput("ovf_set", ovf, 1);
    checkOutput("ovf_wr_valid", wr_valid, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", ovf, 0);
    applyStimulus(2'b01, 1'b0, 5'h1E, 8'hEE);
    phi2Pulse(10, 1'b0, 1'b1);
    checkOutput("ovf_set_beats_clr", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared_2", ovf, 0);
    wr_ready = 1'b1;
    repeat (FDEPTH + 3) tick();
    checkOutput("ovf_drained", wr_valid, 0);
    checkOutput("ovf_sb_empty", exp_q.size(), 0);

    $display("[TB] push into full FIFO with concurrent pop");
    wr_ready = 1'b0;
    for (int k = 0; k < FDEPTH; k++) begin
      applyStimulus(2'b10, 1'b0, 5'(8 + k), 8'(8'h40 + k));
      exp_q.push_back({1'b0, 5'(8 + k), 8'(8'h40 + k)});
      phi2Pulse(10, 1'b0, 1'b0);
    end
    applyStimulus(2'b10, 1'b0, 5'h11, 8'h99);
    exp_q.push_back({1'b0, 5'h11, 8'h99});
    phi2Pulse(10, 1'b1, 1'b0);
    checkOutput("full_pp_ovf", ovf, 0);
    checkOutput("full_pp_valid", wr_valid, 1);
    checkOutput("full_pp_sb_size", exp_q.size(), FDEPTH);
    wr_ready = 1'b1;
    repeat (FDEPTH + 3) tick();
    checkOutput("full_pp_drained", wr_valid, 0);
    checkOutput("full_pp_sb_empty", exp_q.size(), 0);

    $display("[TB] short phi2 high and address glitch");
    applyStimulus(2'b00, 1'b0, 5'h0A, 8'h33);
    e0 = en_cnt;
    pad_phi2_i = 1'b1;
    tick();
    pad_a_i = 5'h15;
    repeat (DB_LEN - 1) tick();
    pad_a_i = 5'h0A;
    repeat (RISE_LEN - 1 - DB_LEN) tick();
    pad_phi2_i = 1'b0;
    repeat (10) tick();
    checkOutput("glitch_no_clk_en", en_cnt - e0, 0);
    checkOutput("glitch_raddr", bus_raddr, 5'h0A);
    checkOutput("glitch_no_push", wr_valid, 0);

    $display("[TB] reset with queued writes");
    wr_ready  = 1'b0;
    bus_rdata = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 1'b0, 5'(k + 20), 8'(8'hC0 + k));
      exp_q.push_back({1'b1, 5'(k + 20), 8'(8'hC0 + k)});
      phi2Pulse(10, 1'b0, 1'b0);
    end
    checkOutput("pre_rst_valid", wr_valid, 1);
    checkOutput("pre_rst_pad_d_o", pad_d_o, 8'h5A);
    pad_phi2_i = 1'b1;
    repeat (10) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_valid", wr_valid, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    checkOutput("mid_rst_clk_en", clk_en, 0);
    checkOutput("mid_rst_rd_strobe", rd_strobe, 0);
    checkOutput("mid_rst_pad_d_oe", pad_d_oe, 0);
    checkOutput("mid_rst_pad_d_o", pad_d_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = en_cnt;
    tick();
    checkOutput("post_rst_raddr", bus_raddr, 0);
    pad_phi2_i = 1'b0;
    repeat (10) tick();
    checkOutput("post_rst_no_clk_en", en_cnt - e0, 0);
    checkOutput("post_rst_wr_valid", wr_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
